// File: rtl/pu_alu_issue.sv
// pu_alu_issue: operand issue stage in front of the processing-unit ALU.
// Accepts decoded instructions, reads both sources from the register file,
// stalls on read-after-write / write-after-write hazards tracked by a
// pending-write scoreboard, and buffers up to two resolved operand bundles.
// The head bundle drives the ex_* outputs.
//
// Optional feature: define PU_ALU_ISSUE_FWD_EN to bypass same-cycle
// writeback data into the captured source operands.

`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 16
`endif

module pu_alu_issue #(
   parameter int IN_WIDTH = `PU_WIDTH_NBITS,
   parameter int RF_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                dec_valid,
   output logic                dec_ready,
   input  logic [4:0]          dec_rs1_idx,
   input  logic [4:0]          dec_rs2_idx,
   input  logic [4:0]          dec_rd_idx,
   input  logic                dec_use_imm,
   input  logic [IN_WIDTH-1:0] dec_imm,
   input  logic [2:0]          dec_funct3,
   input  logic [4:0]          dec_funct5,
   output logic [4:0]          rf_rs1_addr,
   output logic [4:0]          rf_rs2_addr,
   input  logic [RF_WIDTH-1:0] rf_rs1_data,
   input  logic [RF_WIDTH-1:0] rf_rs2_data,
   input  logic                wb_valid,
   input  logic [4:0]          wb_rd,
   input  logic [RF_WIDTH-1:0] wb_data,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [RF_WIDTH-1:0] ex_rs1,
   output logic [RF_WIDTH-1:0] ex_rs2,
   output logic [IN_WIDTH-1:0] ex_imm,
   output logic                ex_use_imm,
   output logic [2:0]          ex_funct3,
   output logic [4:0]          ex_funct5,
   output logic [4:0]          ex_rd
);

   typedef struct packed {
      logic [RF_WIDTH-1:0] rs1;
      logic [RF_WIDTH-1:0] rs2;
      logic [IN_WIDTH-1:0] imm;
      logic                use_imm;
      logic [2:0]          funct3;
      logic [4:0]          funct5;
      logic [4:0]          rd;
   } bundle_t;

   // Two-entry bundle buffer; payload is not reset, occupancy is.
   bundle_t     buf_mem [0:1];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic [31:0] pending;
   logic [31:0] pending_nxt;

   logic        fwd_rs1;
   logic        fwd_rs2;
   logic        hz_rs1;
   logic        hz_rs2;
   logic        hz_rd;
   logic        hz;
   logic        dec_fire;
   logic        ex_fire;
   logic        push;
   logic        pop;
   bundle_t     cap;
   bundle_t     head;

`ifdef PU_ALU_ISSUE_FWD_EN
   // A source matching the writeback in flight takes the writeback data and
   // no longer needs to wait for its pending bit to drop.
   assign fwd_rs1 = wb_valid && (wb_rd == dec_rs1_idx);
   assign fwd_rs2 = wb_valid && (wb_rd == dec_rs2_idx);

   function automatic logic [RF_WIDTH-1:0] sel_operand(
      input logic [4:0]          idx,
      input logic                fwd,
      input logic [RF_WIDTH-1:0] rf_data,
      input logic [RF_WIDTH-1:0] byp_data
   );
      logic [RF_WIDTH-1:0] v;
      if (idx == 5'd0)
         v = '0;
      else if (fwd)
         v = byp_data;
      else
         v = rf_data;
      return v;
   endfunction
`else
   // Without bypass the writeback data is only consumed by the register file.
   assign fwd_rs1 = 1'b0;
   assign fwd_rs2 = 1'b0;

   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;

   function automatic logic [RF_WIDTH-1:0] sel_operand(
      input logic [4:0]          idx,
      input logic                fwd,
      input logic [RF_WIDTH-1:0] rf_data,
      input logic [RF_WIDTH-1:0] byp_data
   );
      logic [RF_WIDTH-1:0] v;
      v = (idx == 5'd0) ? '0 : rf_data;
      if (fwd)
         v = byp_data;
      return v;
   endfunction
`endif

   // Register-file read addresses follow the decode payload directly.
   assign rf_rs1_addr = dec_rs1_idx;
   assign rf_rs2_addr = dec_rs2_idx;

   // Hazard detection and both handshakes.
   always_comb begin
      hz_rs1    = (dec_rs1_idx != 5'd0) && pending[dec_rs1_idx] && !fwd_rs1;
      hz_rs2    = (dec_rs2_idx != 5'd0) && pending[dec_rs2_idx] && !fwd_rs2;
      hz_rd     = (dec_rd_idx  != 5'd0) && pending[dec_rd_idx];
      hz        = hz_rs1 || hz_rs2 || hz_rd;
      ex_valid  = (count != 2'd0) && !rst;
      ex_fire   = ex_valid && ex_ready;
      dec_ready = !rst && !flush && !hz && ((count != 2'd2) || ex_fire);
      dec_fire  = dec_valid && dec_ready;
      push      = dec_fire;
      pop       = ex_fire;
   end

   // Assemble the bundle captured this cycle.
   always_comb begin
      cap         = '0;
      cap.rs1     = sel_operand(dec_rs1_idx, fwd_rs1, rf_rs1_data, wb_data);
      cap.rs2     = sel_operand(dec_rs2_idx, fwd_rs2, rf_rs2_data, wb_data);
      cap.imm     = dec_imm;
      cap.use_imm = dec_use_imm;
      cap.funct3  = dec_funct3;
      cap.funct5  = dec_funct5;
      cap.rd      = dec_rd_idx;
   end

   // Scoreboard update: writeback clears, a same-cycle capture of the same
   // destination re-sets and wins. x0 never becomes pending.
   always_comb begin
      pending_nxt = pending;
      if (wb_valid)
         pending_nxt[wb_rd] = 1'b0;
      if (dec_fire && (dec_rd_idx != 5'd0))
         pending_nxt[dec_rd_idx] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Control state: occupancy, pointers and scoreboard.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count   <= 2'd0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         pending <= '0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         pending <= pending_nxt;
      end
   end

   // Bundle payload: written only on an accepted decode, never refreshed.
   always_ff @(posedge clk) begin
      if (push)
         buf_mem[wr_ptr] <= cap;
   end

   // Head bundle drives the execute port; zero whenever nothing is offered.
   always_comb begin
      head       = ex_valid ? buf_mem[rd_ptr] : '0;
      ex_rs1     = head.rs1;
      ex_rs2     = head.rs2;
      ex_imm     = head.imm;
      ex_use_imm = head.use_imm;
      ex_funct3  = head.funct3;
      ex_funct5  = head.funct5;
      ex_rd      = head.rd;
   end

endmodule

// File: tb/tb_pu_alu_issue.sv
// Testbench for pu_alu_issue: directed scenarios followed by a randomized
// run, all checked against a queue/scoreboard reference model.

`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 16
`endif

module tb_pu_alu_issue;

   localparam int IN_WIDTH = `PU_WIDTH_NBITS;
   localparam int RF_WIDTH = 32;
`ifdef PU_ALU_ISSUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                clk;
   logic                rst;
   logic                flush;
   logic                dec_valid;
   logic                dec_ready;
   logic [4:0]          dec_rs1_idx;
   logic [4:0]          dec_rs2_idx;
   logic [4:0]          dec_rd_idx;
   logic                dec_use_imm;
   logic [IN_WIDTH-1:0] dec_imm;
   logic [2:0]          dec_funct3;
   logic [4:0]          dec_funct5;
   logic [4:0]          rf_rs1_addr;
   logic [4:0]          rf_rs2_addr;
   logic [RF_WIDTH-1:0] rf_rs1_data;
   logic [RF_WIDTH-1:0] rf_rs2_data;
   logic                wb_valid;
   logic [4:0]          wb_rd;
   logic [RF_WIDTH-1:0] wb_data;
   logic                ex_valid;
   logic                ex_ready;
   logic [RF_WIDTH-1:0] ex_rs1;
   logic [RF_WIDTH-1:0] ex_rs2;
   logic [IN_WIDTH-1:0] ex_imm;
   logic                ex_use_imm;
   logic [2:0]          ex_funct3;
   logic [4:0]          ex_funct5;
   logic [4:0]          ex_rd;

   pu_alu_issue #(.IN_WIDTH(IN_WIDTH), .RF_WIDTH(RF_WIDTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1_idx(dec_rs1_idx), .dec_rs2_idx(dec_rs2_idx), .dec_rd_idx(dec_rd_idx),
      .dec_use_imm(dec_use_imm), .dec_imm(dec_imm),
      .dec_funct3(dec_funct3), .dec_funct5(dec_funct5),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_use_imm(ex_use_imm),
      .ex_funct3(ex_funct3), .ex_funct5(ex_funct5), .ex_rd(ex_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic [RF_WIDTH-1:0] rs1;
      logic [RF_WIDTH-1:0] rs2;
      logic [IN_WIDTH-1:0] imm;
      logic                use_imm;
      logic [2:0]          funct3;
      logic [4:0]          funct5;
      logic [4:0]          rd;
   } bnd_t;

   // Reference model state: expected buffer contents and registers awaiting writeback.
   bnd_t                q[$];
   bit [31:0]           pend;
   logic [IN_WIDTH-1:0] fired[$];
   int                  total;
   int                  bad;
   logic                smp_rdy;
   logic                smp_acc;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_src_hz(input logic [4:0] idx);
      return (idx != 5'd0) && pend[idx] && !(FWD && wb_valid && (wb_rd == idx));
   endfunction

   function automatic logic [RF_WIDTH-1:0] model_operand(input logic [4:0] idx,
                                                         input logic [RF_WIDTH-1:0] rfd);
      if (idx == 5'd0) return '0;
      if (FWD && wb_valid && (wb_rd == idx)) return wb_data;
      return rfd;
   endfunction

   // One clock: called just after a falling edge with inputs settled.
   task automatic tick();
      bit   exp_valid;
      bit   exp_fire;
      bit   exp_rdy;
      bit   hz;
      bnd_t b;
      bnd_t nb;
      #4;
      exp_valid = !rst && (q.size() != 0);
      exp_fire  = exp_valid && ex_ready;
      hz        = model_src_hz(dec_rs1_idx) || model_src_hz(dec_rs2_idx) ||
                  ((dec_rd_idx != 5'd0) && pend[dec_rd_idx]);
      exp_rdy   = !rst && !flush && !hz && ((q.size() < 2) || exp_fire);
      smp_rdy   = dec_ready;
      smp_acc   = dec_ready && dec_valid;
      check_val("dec_ready", {63'd0, dec_ready}, {63'd0, exp_rdy});
      check_val("ex_valid", {63'd0, ex_valid}, {63'd0, exp_valid});
      check_val("rf_addr", {54'd0, rf_rs1_addr, rf_rs2_addr}, {54'd0, dec_rs1_idx, dec_rs2_idx});
      b = exp_valid ? q[0] : '0;
      check_val("ex_rs1", {32'd0, ex_rs1}, {32'd0, b.rs1});
      check_val("ex_rs2", {32'd0, ex_rs2}, {32'd0, b.rs2});
      check_val("ex_ctl", 64'({ex_imm, ex_use_imm, ex_funct3, ex_funct5, ex_rd}),
                64'({b.imm, b.use_imm, b.funct3, b.funct5, b.rd}));
      if (ex_valid && ex_ready) fired.push_back(ex_imm);
      if (rst || flush) begin
         q.delete();
         pend = '0;
      end else begin
         if (exp_fire) void'(q.pop_front());
         if (dec_valid && exp_rdy) begin
            nb.rs1     = model_operand(dec_rs1_idx, rf_rs1_data);
            nb.rs2     = model_operand(dec_rs2_idx, rf_rs2_data);
            nb.imm     = dec_imm;
            nb.use_imm = dec_use_imm;
            nb.funct3  = dec_funct3;
            nb.funct5  = dec_funct5;
            nb.rd      = dec_rd_idx;
            q.push_back(nb);
         end
         if (wb_valid) pend[wb_rd] = 1'b0;
         if (dec_valid && exp_rdy && (dec_rd_idx != 5'd0)) pend[dec_rd_idx] = 1'b1;
         pend[0] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic set_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [IN_WIDTH-1:0] imm);
      dec_valid   = 1'b1;
      dec_rs1_idx = rs1;
      dec_rs2_idx = rs2;
      dec_rd_idx  = rd;
      dec_imm     = imm;
      dec_use_imm = imm[0];
      dec_funct3  = imm[3:1];
      dec_funct5  = rd ^ rs1;
   endtask

   task automatic do_flush();
      dec_valid = 1'b0;
      wb_valid  = 1'b0;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
   endtask

   initial begin
      int acc_k;
      total = 0;
      bad   = 0;
      pend  = '0;
      rst = 1'b1; flush = 1'b0; dec_valid = 1'b0;
      dec_rs1_idx = '0; dec_rs2_idx = '0; dec_rd_idx = '0;
      dec_use_imm = 1'b0; dec_imm = '0; dec_funct3 = '0; dec_funct5 = '0;
      rf_rs1_data = '0; rf_rs2_data = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;

      // Reset then idle
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_val("idle_ready", {63'd0, smp_rdy}, 64'd1);

      // Back-to-back independent instructions
      ex_ready = 1'b1;
      set_dec(5'd2, 5'd3, 5'd1, 16'h0011);
      rf_rs1_data = 32'd10; rf_rs2_data = 32'd20;
      tick();
      set_dec(5'd5, 5'd6, 5'd4, 16'h0022);
      rf_rs1_data = 32'd30; rf_rs2_data = 32'd40;
      check_val("b2b_a", {ex_rs1, ex_rs2}, {32'd10, 32'd20});
      tick();
      check_val("b2b_no_stall", {63'd0, smp_acc}, 64'd1);
      dec_valid = 1'b0;
      check_val("b2b_b", {ex_rs1, ex_rs2}, {32'd30, 32'd40});
      tick();
      do_flush();

      // RAW stall on x1, writeback three cycles after the writer
      set_dec(5'd2, 5'd3, 5'd1, 16'h0100);
      rf_rs1_data = 32'd1; rf_rs2_data = 32'd2;
      tick();
      set_dec(5'd1, 5'd2, 5'd8, 16'h0200);
      rf_rs1_data = 32'h99;
      acc_k = -1;
      for (int k = 1; k <= 6 && acc_k < 0; k++) begin
         wb_valid = (k == 3);
         wb_rd    = 5'd1;
         wb_data  = 32'h55;
         tick();
         if (smp_acc) acc_k = k;
      end
      dec_valid = 1'b0;
      wb_valid  = 1'b0;
      check_val("raw_accept_cycle", 64'(acc_k), FWD ? 64'd3 : 64'd4);
      check_val("raw_rs1", {32'd0, ex_rs1}, FWD ? 64'h55 : 64'h99);
      tick();
      do_flush();

      // Backpressure: three offers, two fit
      ex_ready = 1'b0;
      fired.delete();
      set_dec(5'd0, 5'd0, 5'd0, 16'h00A1);
      tick();
      set_dec(5'd0, 5'd0, 5'd0, 16'h00B2);
      tick();
      set_dec(5'd0, 5'd0, 5'd0, 16'h00C3);
      tick();
      check_val("bp_third_blocked", {63'd0, smp_rdy}, 64'd0);
      tick();
      check_val("bp_head_stable", 64'(ex_imm), 64'h00A1);
      ex_ready = 1'b1;
      acc_k = -1;
      for (int k = 0; k < 5 && acc_k < 0; k++) begin
         tick();
         if (smp_acc) acc_k = k;
      end
      dec_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_val("bp_drain_count", 64'(fired.size()), 64'd3);
      if (fired.size() == 3) begin
         check_val("bp_order_a", 64'(fired[0]), 64'h00A1);
         check_val("bp_order_b", 64'(fired[1]), 64'h00B2);
         check_val("bp_order_c", 64'(fired[2]), 64'h00C3);
      end

      // x0 handling
      do_flush();
      set_dec(5'd2, 5'd3, 5'd0, 16'h0031);
      tick();
      set_dec(5'd0, 5'd5, 5'd10, 16'h0032);
      rf_rs1_data = 32'hFFFF_FFFF;
      tick();
      check_val("x0_no_stall", {63'd0, smp_acc}, 64'd1);
      dec_valid = 1'b0;
      check_val("x0_rs1_zero", {32'd0, ex_rs1}, 64'd0);
      tick();

      // Flush with a full buffer and x7 pending
      do_flush();
      ex_ready = 1'b0;
      set_dec(5'd0, 5'd0, 5'd0, 16'h0041);
      tick();
      set_dec(5'd0, 5'd0, 5'd7, 16'h0042);
      tick();
      set_dec(5'd7, 5'd0, 5'd9, 16'h0043);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
      tick();
      check_val("flush_reader_accept", {63'd0, smp_rdy}, 64'd1);
      dec_valid = 1'b0;
      tick();
      do_flush();

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 199) == 0);
         flush       = ($urandom_range(0, 99) == 0);
         dec_valid   = ($urandom_range(0, 9) < 7);
         dec_rs1_idx = 5'($urandom_range(0, 7));
         dec_rs2_idx = 5'($urandom_range(0, 7));
         dec_rd_idx  = 5'($urandom_range(0, 7));
         dec_use_imm = 1'($urandom);
         dec_imm     = IN_WIDTH'($urandom);
         dec_funct3  = 3'($urandom);
         dec_funct5  = 5'($urandom);
         rf_rs1_data = $urandom;
         rf_rs2_data = $urandom;
         wb_valid    = ($urandom_range(0, 9) < 4);
         wb_rd       = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
         ex_ready    = ($urandom_range(0, 9) < 7);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
